// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Frame FSM and receiver state encodings, frame field widths, baud helper.
// No logic; imported by the receiver and the loader top.
package uart_imem_loader_pkg;

    localparam int COUNT_W = 16;   // width of the big-endian word count header
    localparam int WORD_W  = 32;   // instruction word / byte address width
    localparam int BYTE_W  = 8;    // UART payload width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Nearest whole number of clocks per UART bit for a given clock and baud.
    function automatic int unsigned default_clks_per_bit(input int unsigned clk_hz,
                                                         input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_imem_loader_rx.sv
// 8N1 UART byte receiver with 2-flop input synchronizer and glitch-rejecting start check.
// Latency: byte_vld_o pulses one cycle after the stop bit is sampled mid-bit.
// No backpressure: each byte/error is a single-cycle pulse the consumer must take.
module uart_rx_byte
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = default_clks_per_bit(100_000_000, 115_200)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_i,
    output logic              byte_vld_o,
    output logic [BYTE_W-1:0] byte_dat_o,
    output logic              frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]        sync_q;
    logic              prev_q;
    logic              rx_s;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              vld_q, vld_d;
    logic              ferr_q, ferr_d;

    assign rx_s        = sync_q[1];
    assign byte_vld_o  = vld_q;
    assign byte_dat_o  = shift_q;
    assign frame_err_o = ferr_q;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= sync_q[1];
        end
    end

    // Receiver state, bit timer and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    // Start edge detect, half-bit start recheck, mid-bit data/stop sampling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A line already back high at mid start bit was a glitch.
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[BYTE_W-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    vld_d   = rx_s;
                    ferr_d  = !rx_s;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: parses a UART image frame and writes words into instruction RAM.
// Latency: imem_we pulses the cycle after the 4th byte of each word is received.
// No backpressure: RAM accepts one write per cycle; CPU held in reset while loading.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT    = default_clks_per_bit(100_000_000, 115_200),
    parameter int ADDR_WORDS_LOG2 = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    input  logic              load_en,
    output logic              cpu_hold,
    output logic              imem_we,
    output logic [WORD_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned MAX_WORDS = 1 << ADDR_WORDS_LOG2;

    logic               rx_vld;
    logic [BYTE_W-1:0]  rx_byte;
    logic               rx_ferr;

    ld_state_e          state_q, state_d;
    logic [COUNT_W-1:0] n_q, n_d;
    logic [COUNT_W-1:0] words_q, words_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [BYTE_W-1:0]  xor_q, xor_d;
    logic               hold_q, hold_d;
    logic               we_q, we_d;
    logic [WORD_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               en_prev_q;

    logic               loading;
    logic               start_load;
    logic [COUNT_W-1:0] n_shift;
    logic [WORD_W-1:0]  word_shift;
    logic               n_bad;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx_i       (uart_rx),
        .byte_vld_o (rx_vld),
        .byte_dat_o (rx_byte),
        .frame_err_o(rx_ferr)
    );

    assign n_shift    = {n_q[BYTE_W-1:0], rx_byte};
    assign word_shift = {word_q[WORD_W-BYTE_W-1:0], rx_byte};
    assign n_bad      = (n_shift == '0) || (32'(n_shift) > MAX_WORDS);

    assign cpu_hold   = hold_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

    // Frame FSM state, counters, word assembly and registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            words_q   <= '0;
            bcnt_q    <= '0;
            word_q    <= '0;
            xor_q     <= '0;
            hold_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            words_q   <= words_d;
            bcnt_q    <= bcnt_d;
            word_q    <= word_d;
            xor_q     <= xor_d;
            hold_q    <= hold_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            en_prev_q <= load_en;
        end
    end

    // Next-state logic: abort and framing errors take priority over byte handling.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        words_d    = words_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        xor_d      = xor_q;
        hold_d     = hold_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        err_d      = err_q;
        start_load = 1'b0;
        loading    = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                     (state_q == ST_DATA)   || (state_q == ST_CSUM);

        if (loading && !load_en) begin
            // Abort: words already written stay in RAM, CPU is released.
            state_d = ST_IDLE;
            hold_d  = 1'b0;
            done_d  = 1'b0;
        end else if (loading && rx_ferr) begin
            state_d = ST_ERR;
            hold_d  = 1'b1;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hold_d     = 1'b0;
                    start_load = load_en;
                end
                ST_HDR_HI: begin
                    if (rx_vld) begin
                        n_d     = n_shift;
                        state_d = ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (rx_vld) begin
                        n_d = n_shift;
                        if (n_bad) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_vld) begin
                        word_d = word_shift;
                        xor_d  = xor_q ^ rx_byte;
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == 2'd3) begin
                            we_d    = 1'b1;
                            addr_d  = WORD_W'(words_q[ADDR_WORDS_LOG2-1:0]) << 2;
                            wdata_d = word_shift;
                            words_d = words_q + 1'b1;
                            if ((words_q + 1'b1) == n_q) begin
                                state_d = ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_vld) begin
                        if (rx_byte == xor_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Only a fresh rising edge of load_en starts another image.
                    start_load = load_en && !en_prev_q;
                end
                ST_ERR: begin
                    if (!load_en) begin
                        state_d = ST_IDLE;
                        hold_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (start_load) begin
                state_d = ST_HDR_HI;
                hold_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
                n_d     = '0;
                words_d = '0;
                bcnt_d  = '0;
                word_d  = '0;
                xor_d   = '0;
            end
        end
    end

endmodule
